// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's valid/ready request channel and response channel
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic req_valid, req_ready;
  logic [3:0] req_op;
  logic [DATA_W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0] rsp_flags;
  modport master(output req_valid, req_op, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_result, rsp_flags);
  modport slave(input req_valid, req_op, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_result, rsp_flags);
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester ALU front end; ALU_ARB_SHARED_FLAGS_EN selects one shared flag register
module alu_arbiter #(parameter int DATA_W = 32) (
  input  logic clk,
  input  logic rst_n,
  alu_arbiter_if.slave port0,
  alu_arbiter_if.slave port1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0] alu_flags,
  input  logic alu_finished,
  output logic halted,
  input  logic resume
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;
  state_t state;
  logic own, last, fin, rv0, rv1, g0, g1, take, zero_op;
  logic [DATA_W-1:0] res;
  function automatic logic [3:0] upd(input logic [3:0] op, input logic [3:0] old, input logic [3:0] nf);
    return (op inside {4'b0000, 4'b0001, 4'b0110, 4'b1000, 4'b1010}) ? nf :
           (op inside {[4'b0010:4'b0101]}) ? {nf[3:2], old[1:0]} : old;
  endfunction
  // on a tie, the requester not granted last wins
  assign g1 = port1.req_valid && (!port0.req_valid || !last);
  assign g0 = port0.req_valid && !g1;
  assign take = rst_n && state == IDLE;
  assign port0.req_ready = take && g0;
  assign port1.req_ready = take && g1;
  assign zero_op = alu_ctrl inside {4'b0111, [4'b1011:4'b1111]};
  assign port0.rsp_valid = rv0;
  assign port1.rsp_valid = rv1;
  assign port0.rsp_result = res;
  assign port1.rsp_result = res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      own <= 1'b0;
      last <= 1'b1;
      fin <= 1'b0;
      res <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      halted <= 1'b0;
    end else case (state)
      IDLE: if (g0 || g1) begin
        own <= g1;
        last <= g1;
        alu_ctrl <= g1 ? port1.req_op : port0.req_op;
        alu_a <= g1 ? port1.req_a : port0.req_a;
        alu_b <= g1 ? port1.req_b : port0.req_b;
        state <= EXEC;
      end
      EXEC: begin
        res <= zero_op ? '0 : alu_result;
        fin <= alu_finished;
        rv0 <= !own;
        rv1 <= own;
        state <= RESP;
      end
      RESP: if (own ? port1.rsp_ready : port0.rsp_ready) begin
        rv0 <= 1'b0;
        rv1 <= 1'b0;
        halted <= fin;
        state <= fin ? HALT : IDLE;
      end
      HALT: if (resume) begin
        halted <= 1'b0;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
`ifdef ALU_ARB_SHARED_FLAGS_EN
  logic [3:0] fl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fl <= '0;
    else if (state == EXEC) fl <= upd(alu_ctrl, fl, alu_flags);
  assign port0.rsp_flags = fl;
  assign port1.rsp_flags = fl;
`else
  logic [3:0] fl0, fl1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fl0 <= '0;
      fl1 <= '0;
    end else if (state == EXEC) begin
      fl0 <= own ? fl0 : upd(alu_ctrl, fl0, alu_flags);
      fl1 <= own ? upd(alu_ctrl, fl1, alu_flags) : fl1;
    end
  assign port0.rsp_flags = fl0;
  assign port1.rsp_flags = fl1;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, flag rules, stall, reset and halt/resume
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, resume = 1'b0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl, alu_flags;
  logic alu_finished, halted;
  logic [32:0] ext;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_arbiter_if p0();
  alu_arbiter_if p1();
  alu_arbiter dut(.clk(clk), .rst_n(rst_n), .port0(p0), .port1(p1), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags), .alu_finished(alu_finished),
    .halted(halted), .resume(resume));
  // stand-in ALU: ADD 0000, SUB 0001, AND 0010, MOV 0101, CMP 0110, STR 1001, BLx 1011; C is carry/borrow
  always_comb begin
    ext = '0;
    case (alu_ctrl)
      4'b0000: ext = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001, 4'b0110: ext = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: ext = {1'b0, alu_a & alu_b};
      4'b0101: ext = {1'b0, alu_b};
      4'b1001: ext = {1'b0, alu_a};
      default: ext = {1'b0, alu_a | alu_b};
    endcase
    alu_result = ext[31:0];
    alu_flags = {ext[31], ext[31:0] == 32'h0, ext[32], 1'b0};
    alu_finished = alu_ctrl == 4'b1011;
  end
  task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin p0.req_valid = v; p0.req_op = op; p0.req_a = a; p0.req_b = b; end
    else begin p1.req_valid = v; p1.req_op = op; p1.req_a = a; p1.req_b = b; end
  endtask
  task automatic set_rr(input int p, input logic v);
    if (p == 0) p0.rsp_ready = v; else p1.rsp_ready = v;
  endtask
  function automatic logic rdy(input int p);
    return p == 0 ? p0.req_ready : p1.req_ready;
  endfunction
  function automatic logic vld(input int p);
    return p == 0 ? p0.rsp_valid : p1.rsp_valid;
  endfunction
  function automatic logic [31:0] rres(input int p);
    return p == 0 ? p0.rsp_result : p1.rsp_result;
  endfunction
  function automatic logic [3:0] rfl(input int p);
    return p == 0 ? p0.rsp_flags : p1.rsp_flags;
  endfunction
  // one full transaction from a negedge; lat counts negedges from accept edge to rsp_valid, -1 on timeout
  task automatic run(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output logic [3:0] f, output int lat);
    int n = 0;
    lat = -1; r = 'x; f = 'x;
    set_req(p, 1'b1, op, a, b);
    #1;
    while (!rdy(p) && n < 20) begin @(negedge clk); #1; n++; end
    if (!rdy(p)) begin set_req(p, 1'b0, 4'h0, 0, 0); return; end
    @(posedge clk);
    #1 set_req(p, 1'b0, 4'h0, 0, 0);
    n = 1;
    @(negedge clk);
    while (!vld(p) && n < 20) begin @(negedge clk); n++; end
    if (!vld(p)) return;
    lat = n; r = rres(p); f = rfl(p);
    set_rr(p, 1'b1);
    @(posedge clk);
    #1 set_rr(p, 1'b0);
    @(negedge clk);
  endtask
  task automatic test_reset;
    total++; if ({rdy(0), rdy(1), vld(0), vld(1), halted} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=00000", {rdy(0), rdy(1), vld(0), vld(1), halted}); end
    total++; if ({rres(0), rres(1)} !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", {rres(0), rres(1)}); end
    total++; if ({alu_a, alu_b, alu_ctrl} !== 68'h0) begin bad++; $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_ctrl}); end
    total++; if ({rfl(0), rfl(1)} !== 8'h0) begin bad++; $display("FAIL reset_flags got=%b want=0", {rfl(0), rfl(1)}); end
  endtask
  task automatic test_tie;
    logic [31:0] r; logic [3:0] f; int lat;
    set_req(0, 1'b1, 4'b0001, 3, 3);
    set_req(1, 1'b1, 4'b0101, 0, 32'h8000_0000);
    #1;
    total++; if ({rdy(0), rdy(1)} !== 2'b10) begin bad++; $display("FAIL tie_ready got=%b want=10", {rdy(0), rdy(1)}); end
    @(posedge clk);
    #1 set_req(0, 1'b0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if ({rdy(1), vld(0), vld(1)} !== 3'b000) begin bad++; $display("FAIL tie_exec got=%b want=000", {rdy(1), vld(0), vld(1)}); end
    @(negedge clk);
    total++; if ({vld(0), vld(1)} !== 2'b10) begin bad++; $display("FAIL tie_rsp_valid got=%b want=10", {vld(0), vld(1)}); end
    total++; if ({rres(0), rfl(0)} !== {32'h0, 4'b0100}) begin bad++; $display("FAIL tie_sub got=%h/%b want=0/0100", rres(0), rfl(0)); end
    set_rr(0, 1'b1);
    @(posedge clk);
    #1 set_rr(0, 1'b0);
    @(negedge clk);
    total++; if (rdy(1) !== 1'b1) begin bad++; $display("FAIL tie_loser_ready got=%b want=1", rdy(1)); end
    run(1, 4'b0101, 0, 32'h8000_0000, r, f, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL tie_mov_latency got=%0d want=2", lat); end
    total++; if ({r, f} !== {32'h8000_0000, 4'b1000}) begin bad++; $display("FAIL tie_mov got=%h/%b want=80000000/1000", r, f); end
  endtask
  task automatic test_add;
    logic [31:0] r; logic [3:0] f; int lat;
    run(0, 4'b0000, 5, 7, r, f, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
    total++; if (r !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=0000000c", r); end
    total++; if (f !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b want=0000", f); end
  endtask
  task automatic test_cmp_and;
    logic [31:0] r; logic [3:0] f; int lat;
    run(1, 4'b0110, 1, 2, r, f, lat);
    total++; if ({r, f} !== {32'hFFFF_FFFF, 4'b1010}) begin bad++; $display("FAIL cmp got=%h/%b want=ffffffff/1010", r, f); end
    run(1, 4'b0010, 32'hF, 32'hF, r, f, lat);
    total++; if ({r, f} !== {32'hF, 4'b0010}) begin bad++; $display("FAIL and_cv_kept got=%h/%b want=0000000f/0010", r, f); end
    run(1, 4'b1111, 4, 1, r, f, lat);
    total++; if ({r, f} !== {32'h0, 4'b0010}) begin bad++; $display("FAIL undef_op got=%h/%b want=0/0010", r, f); end
    total++; if (rfl(0) !== 4'b0000) begin bad++; $display("FAIL req0_flags_untouched got=%b want=0000", rfl(0)); end
  endtask
  task automatic test_stall_reset;
    int errs = 0;
    set_req(0, 1'b1, 4'b0001, 1, 2);
    #1;
    total++; if (rdy(0) !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", rdy(0)); end
    @(posedge clk);
    #1 set_req(0, 1'b0, 4'h0, 0, 0);
    set_req(1, 1'b1, 4'b0000, 8, 8);
    @(negedge clk);
    @(negedge clk);
    repeat (10) begin
      if ({vld(0), vld(1), rdy(1)} !== 3'b100 || rres(0) !== 32'hFFFF_FFFF || rfl(0) !== 4'b1010) errs++;
      @(negedge clk);
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL stall_hold got=%0d bad cycles want=0", errs); end
    rst_n = 1'b0;
    #1;
    total++; if ({vld(0), vld(1), rdy(0), rdy(1), halted} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {vld(0), vld(1), rdy(0), rdy(1), halted}); end
    total++; if ({rres(0), alu_a, alu_b, alu_ctrl} !== 100'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {rres(0), alu_a, alu_b, alu_ctrl}); end
    total++; if ({rfl(0), rfl(1)} !== 8'h0) begin bad++; $display("FAIL rst_flags got=%b want=0", {rfl(0), rfl(1)}); end
    set_req(1, 1'b0, 4'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_flags_cfg;
    logic [31:0] r; logic [3:0] f; int lat;
    logic [3:0] want;
`ifdef ALU_ARB_SHARED_FLAGS_EN
    want = 4'b0100;
`else
    want = 4'b0000;
`endif
    run(0, 4'b0110, 0, 0, r, f, lat);
    total++; if ({r, f} !== {32'h0, 4'b0100}) begin bad++; $display("FAIL cfg_cmp got=%h/%b want=0/0100", r, f); end
    run(1, 4'b1001, 32'h55, 0, r, f, lat);
    total++; if ({r, f} !== {32'h55, want}) begin bad++; $display("FAIL cfg_str got=%h/%b want=00000055/%b", r, f, want); end
  endtask
  task automatic test_halt;
    logic [31:0] r; logic [3:0] f; int lat;
    int errs = 0;
    run(0, 4'b1011, 32'h1234, 1, r, f, lat);
    total++; if ({r, f} !== {32'h0, 4'b0100}) begin bad++; $display("FAIL blx got=%h/%b want=0/0100", r, f); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", halted); end
    set_req(1, 1'b1, 4'b0101, 0, 9);
    repeat (5) begin
      #1 if (rdy(1) !== 1'b0 || halted !== 1'b1) errs++;
      @(negedge clk);
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL halt_hold got=%0d bad cycles want=0", errs); end
    resume = 1'b1;
    #1;
    total++; if (rdy(1) !== 1'b0) begin bad++; $display("FAIL resume_same_cycle got=%b want=0", rdy(1)); end
    @(posedge clk);
    #1 resume = 1'b0;
    total++; if ({rdy(1), halted} !== 2'b10) begin bad++; $display("FAIL resume_grant got=%b want=10", {rdy(1), halted}); end
    run(1, 4'b0101, 0, 9, r, f, lat);
    total++; if ({r, f, lat} !== {32'd9, 4'b0000, 32'd2}) begin bad++; $display("FAIL post_resume got=%h/%b/%0d want=9/0000/2", r, f, lat); end
  endtask
  initial begin
    p0.req_valid = 1'b0; p0.req_op = '0; p0.req_a = '0; p0.req_b = '0; p0.rsp_ready = 1'b0;
    p1.req_valid = 1'b0; p1.req_op = '0; p1.req_a = '0; p1.req_b = '0; p1.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    test_tie();
    test_add();
    test_cmp_and();
    test_stall_reset();
    test_flags_cfg();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
